// File: rtl/shift_add_multiplier_pkg.sv
// mult_pkg: shared types and sizing for the shift_add_multiplier slice.
// Holds the controller state encoding, the verified operand width and the
// iteration counter width derived from it.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int MULT_W = 8;
   localparam int CNT_W  = $clog2(MULT_W) + 1;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: operand/product handshake bundle.
// master = requester/consumer side, slave = multiplier.
// Optional: MULT_OVF_EN adds the ovf signal.
interface shift_add_multiplier_if
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_W
) ();

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] product;
   logic               busy;
`ifdef MULT_OVF_EN
   logic               ovf;
`endif

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product, busy
`ifdef MULT_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product, busy
`ifdef MULT_OVF_EN
      , output ovf
`endif
   );

endinterface

// File: rtl/shift_add_multiplier_adder.sv
// full_adder / ripple_adder_w: the team's WIDTH-bit ripple-carry adder,
// built from single-bit full adder cells, with carry-in and carry-out.

module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);
   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module ripple_adder_w #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
);
   logic [WIDTH:0] w_carry;

   assign w_carry[0] = i_cin;
   assign o_cout     = w_carry[WIDTH];

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      full_adder u_fa (
         .i_a    (i_a[gi]),
         .i_b    (i_b[gi]),
         .i_cin  (w_carry[gi]),
         .o_sum  (o_sum[gi]),
         .o_cout (w_carry[gi+1])
      );
   end
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: multi-cycle unsigned WIDTH x WIDTH multiplier that
// reuses one ripple-carry adder over WIDTH shift-and-add iterations.
// Accept -> WIDTH RUN cycles -> DONE holds the product until consumed.
// Optional: define MULT_OVF_EN for a registered ovf output (upper half != 0).
module shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_W
) (
   input logic                   clk,
   input logic                   rst,
   shift_add_multiplier_if.slave bus
);

   // Counter must reach WIDTH-1; the package width covers the verified size.
   localparam int CW = (WIDTH == MULT_W) ? CNT_W : $clog2(WIDTH) + 1;

   state_t             r_state;
   logic [WIDTH-1:0]   r_m;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_q;
   logic [CW-1:0]      r_cnt;
   logic               r_in_ready;
   logic               r_out_valid;
   logic               r_busy;
   logic [2*WIDTH-1:0] r_product;
`ifdef MULT_OVF_EN
   logic               r_ovf;
`endif

   logic [WIDTH-1:0]   w_sum;
   logic               w_cout;
   logic [WIDTH-1:0]   w_acc_nxt;
   logic [WIDTH-1:0]   w_q_nxt;

   // Single shared adder: acc + m, carry-in tied low.
   ripple_adder_w #(.WIDTH(WIDTH)) u_adder (
      .i_a    (r_acc),
      .i_b    (r_m),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // One shift-and-add step: add m when q[0] is set, then shift {acc,q} right,
   // with the adder carry-out becoming the new acc MSB so nothing is lost.
   always_comb begin
      w_acc_nxt = {1'b0, r_acc[WIDTH-1:1]};
      w_q_nxt   = {r_acc[0], r_q[WIDTH-1:1]};
      if (r_q[0]) begin
         w_acc_nxt = {w_cout, w_sum[WIDTH-1:1]};
         w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
      end
   end

   // Controller FSM with registered handshake outputs; product is captured
   // only on DONE entry so partial sums never reach the port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_m         <= '0;
         r_acc       <= '0;
         r_q         <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_product   <= '0;
`ifdef MULT_OVF_EN
         r_ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_m        <= bus.a;
                  r_q        <= bus.b;
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               r_acc <= w_acc_nxt;
               r_q   <= w_q_nxt;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(WIDTH - 1)) begin
                  r_product   <= {w_acc_nxt, w_q_nxt};
                  r_out_valid <= 1'b1;
`ifdef MULT_OVF_EN
                  r_ovf       <= (w_acc_nxt != '0);
`endif
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.busy      = r_busy;
   assign bus.product   = r_product;
`ifdef MULT_OVF_EN
   assign bus.ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed table vectors, handshake corner cases,
// mid-run reset and a randomized operand sweep with output stalls.
module tb_shift_add_multiplier;
   import mult_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   shift_add_multiplier_if #(.WIDTH(MULT_W)) bus ();

   shift_add_multiplier #(.WIDTH(MULT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] prod;
      logic        ovf;
   } vec_t;

   vec_t vecs [10];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Full transaction: accept, count latency, optional consumer stall, handshake.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv,
                         input int stall, input int exp,
                         output logic [15:0] p, output int lat, output logic ov);
      int guard;
      guard = 0;
      while (!bus.in_ready && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("in_ready_before_accept", int'(bus.in_ready), 1);
      bus.out_ready = (stall == 0);
      bus.a         = ta;
      bus.b         = tbv;
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.a        = 8'($urandom);
      bus.b        = 8'($urandom);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      p = bus.product;
`ifdef MULT_OVF_EN
      ov = bus.ovf;
`else
      ov = 1'b0;
`endif
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         chk("stall_product", int'(bus.product), exp);
         chk("stall_out_valid", int'(bus.out_valid), 1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [15:0] p;
      int          lat;
      logic        ov;
      logic [7:0]  ra;
      logic [7:0]  rb;
      int          st;

      vecs[0] = '{8'd13,  8'd11,  16'd143,   1'b0};
      vecs[1] = '{8'd255, 8'd255, 16'd65025, 1'b1};
      vecs[2] = '{8'd0,   8'd200, 16'd0,     1'b0};
      vecs[3] = '{8'd200, 8'd0,   16'd0,     1'b0};
      vecs[4] = '{8'd1,   8'd1,   16'd1,     1'b0};
      vecs[5] = '{8'd255, 8'd1,   16'd255,   1'b0};
      vecs[6] = '{8'd1,   8'd255, 16'd255,   1'b0};
      vecs[7] = '{8'd16,  8'd16,  16'd256,   1'b1};
      vecs[8] = '{8'd128, 8'd2,   16'd256,   1'b1};
      vecs[9] = '{8'd15,  8'd17,  16'd255,   1'b0};

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", int'(bus.in_ready), 1);
      chk("reset_out_valid", int'(bus.out_valid), 0);
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_product", int'(bus.product), 0);
`ifdef MULT_OVF_EN
      chk("reset_ovf", int'(bus.ovf), 0);
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      // Table-driven vectors with out_ready tied high.
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].a, vecs[i].b, 0, int'(vecs[i].prod), p, lat, ov);
         chk("vec_latency", lat, 8);
         chk("vec_product", int'(p), int'(vecs[i].prod));
`ifdef MULT_OVF_EN
         chk("vec_ovf", int'(ov), int'(vecs[i].ovf));
`endif
         chk("vec_idle_in_ready", int'(bus.in_ready), 1);
         chk("vec_idle_out_valid", int'(bus.out_valid), 0);
         chk("vec_idle_busy", int'(bus.busy), 0);
      end

      // Consumer stall in DONE while new operands are offered.
      bus.out_ready = 1'b0;
      bus.a         = 8'd37;
      bus.b         = 8'd91;
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("run_busy", int'(bus.busy), 1);
      chk("run_in_ready", int'(bus.in_ready), 0);
      chk("run_out_valid", int'(bus.out_valid), 0);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("stall_latency", lat, 8);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = (i % 2 == 0);
         bus.a        = 8'd99;
         bus.b        = 8'd77;
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         chk("hold_product", int'(bus.product), 3367);
         chk("hold_in_ready", int'(bus.in_ready), 0);
         chk("hold_out_valid", int'(bus.out_valid), 1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_out_valid", int'(bus.out_valid), 0);
      chk("release_in_ready", int'(bus.in_ready), 1);
      run_op(8'd99, 8'd77, 0, 7623, p, lat, ov);
      chk("after_stall_product", int'(p), 7623);
      chk("after_stall_latency", lat, 8);

      // Reset asserted in the middle of RUN aborts the operation.
      bus.a        = 8'd200;
      bus.b        = 8'd3;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_in_ready", int'(bus.in_ready), 1);
      chk("midrst_out_valid", int'(bus.out_valid), 0);
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_product", int'(bus.product), 0);
      repeat (10) @(posedge clk);
      #1;
      chk("midrst_hold_out_valid", int'(bus.out_valid), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(8'd17, 8'd15, 0, 255, p, lat, ov);
      chk("post_reset_product", int'(p), 255);
      chk("post_reset_latency", lat, 8);

      // Random operand pairs with random consumer stalls.
      for (int n = 0; n < 1000; n++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         st = $urandom_range(0, 3);
         run_op(ra, rb, st, int'(ra) * int'(rb), p, lat, ov);
         chk("rand_product", int'(p), int'(ra) * int'(rb));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
